// File: rtl/alarm_pkg.sv
// Shared types, BCD limits and helpers for the alarm clock core.
package alarm_pkg;

    typedef struct packed {
        logic [3:0] hour_dec;
        logic [3:0] hour_one;
        logic [3:0] min_dec;
        logic [3:0] min_one;
    } bcd_hhmm_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    localparam logic [7:0] MAX_HOUR_BCD = 8'h23;
    localparam logic [7:0] MAX_MIN_BCD  = 8'h59;
    localparam logic [7:0] MAX_SEC_BCD  = 8'h59;

    // Each digit must be decimal and the pairs must lie within a day.
    // BCD pairs order like their binary encodings, so one compare per pair suffices.
    function automatic logic bcd_hhmm_valid(input bcd_hhmm_t t);
        return (t.hour_dec <= 4'd9) && (t.hour_one <= 4'd9) &&
               (t.min_dec  <= 4'd9) && (t.min_one  <= 4'd9) &&
               ({t.hour_dec, t.hour_one} <= MAX_HOUR_BCD) &&
               ({t.min_dec, t.min_one}   <= MAX_MIN_BCD);
    endfunction

    // Two-digit BCD increment that wraps to 00 after max_v.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Seconds prescaler plus HH:MM:SS BCD time-of-day counter with a validated load path.
module bcd_time_counter
    import alarm_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  bcd_hhmm_t  init_i,
    output logic       sec_tick_o,
    output logic       load_err_o,
    output logic       min_start_o,
    output bcd_hhmm_t  hhmm_o,
    output logic [7:0] ss_o
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic          min_start_q, min_start_d;
    logic          tick, load_ok, ss_wrap, mm_wrap;

    assign tick    = (presc_q == PRESC_LAST);
    assign load_ok = load_i && bcd_hhmm_valid(init_i);
    assign ss_wrap = (ss_q == MAX_SEC_BCD);
    assign mm_wrap = (mm_q == MAX_MIN_BCD);

    // Next time: a valid load overrides (and discards) a coincident tick.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        presc_d     = tick ? '0 : presc_q + 1'b1;
        hh_d        = hh_q;
        mm_d        = mm_q;
        ss_d        = ss_q;
        min_start_d = 1'b0;
        if (load_ok) begin
            presc_d = '0;
            hh_d    = {init_i.hour_dec, init_i.hour_one};
            mm_d    = {init_i.min_dec, init_i.min_one};
            ss_d    = 8'h00;
        end else if (tick) begin
            ss_d        = bcd_inc(ss_q, MAX_SEC_BCD);
            min_start_d = ss_wrap;
            if (ss_wrap) begin
                mm_d = bcd_inc(mm_q, MAX_MIN_BCD);
                if (mm_wrap)
                    hh_d = bcd_inc(hh_q, MAX_HOUR_BCD);
            end
        end
    end

    // Time and prescaler registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            presc_q     <= '0;
            hh_q        <= 8'h00;
            mm_q        <= 8'h00;
            ss_q        <= 8'h00;
            min_start_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            hh_q        <= hh_d;
            mm_q        <= mm_d;
            ss_q        <= ss_d;
            min_start_q <= min_start_d;
        end
    end

    assign sec_tick_o  = tick;
    assign load_err_o  = load_i && !bcd_hhmm_valid(init_i);
    assign min_start_o = min_start_q;
    assign hhmm_o      = {hh_q, mm_q};
    assign ss_o        = ss_q;

endmodule

// File: rtl/alarm_clock_multi.sv
// Multi-slot alarm clock core: alarm slots, match priority and IDLE/RING/SNOOZE FSM.
// Optional build macro ALARM_SNOOZE_LIMIT_EN caps snoozes per ring event at MAX_SNOOZE.
module alarm_clock_multi
    import alarm_pkg::*;
#(
    parameter int  TICK_DIV   = 100000000,
    parameter int  N_ALARMS   = 4,
    parameter int  SNOOZE_SEC = 300,
    parameter int  RING_SEC   = 60,
    parameter int  MAX_SNOOZE = 3,
    localparam int IW         = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                time_load,
    input  logic [15:0]         time_init,
    input  logic                alarm_wr,
    input  logic [IW-1:0]       alarm_idx,
    input  logic [15:0]         alarm_hhmm,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic                snooze,
    input  logic                stop,
    output logic [15:0]         time_hhmm,
    output logic [7:0]          time_ss,
    output logic                sec_tick,
    output logic                ringing,
    output logic                snoozing,
    output logic [IW-1:0]       ring_idx,
    output logic                aud_en,
    output logic                cfg_err
);

    localparam int TMAX = (SNOOZE_SEC > RING_SEC) ? SNOOZE_SEC : RING_SEC;
    localparam int TW   = $clog2(TMAX + 1);

    bcd_hhmm_t    hhmm_s;
    logic         tick_s, min_start_s, load_err_s;
    bcd_hhmm_t    slot_q [N_ALARMS];
    logic         wr_ok, wr_err;
    logic         match_hit;
    logic [IW-1:0] match_idx;
    alarm_state_t state_q;
    logic [TW-1:0] timer_q;
    logic [IW-1:0] ring_idx_q;
    logic         ringing_q, snoozing_q, aud_en_q, cfg_err_q;
    logic         ring_en, snooze_req, snooze_rej, snooze_take;

    bcd_time_counter #(.TICK_DIV(TICK_DIV)) u_time (
        .clk        (clk),
        .rst        (rst),
        .load_i     (time_load),
        .init_i     (bcd_hhmm_t'(time_init)),
        .sec_tick_o (tick_s),
        .load_err_o (load_err_s),
        .min_start_o(min_start_s),
        .hhmm_o     (hhmm_s),
        .ss_o       (time_ss)
    );

    assign wr_ok  = alarm_wr && bcd_hhmm_valid(bcd_hhmm_t'(alarm_hhmm)) && (int'(alarm_idx) < N_ALARMS);
    assign wr_err = alarm_wr && !wr_ok;

    // Alarm slot storage, written only by validated requests.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the slot array is reset because every slot must read 00:00 after reset.
        if (rst) begin
            for (int i = 0; i < N_ALARMS; i++)
                slot_q[i] <= '0;
        end else if (wr_ok) begin
            slot_q[alarm_idx] <= bcd_hhmm_t'(alarm_hhmm);
        end
    end

    // Lowest enabled matching slot wins: scan downward so the last hit is the lowest index.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && (slot_q[i] == hhmm_s)) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    assign ring_en    = alarm_en[ring_idx_q];
    assign snooze_req = (state_q == RING) && ring_en && !stop && snooze;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam int SCW = $clog2(MAX_SNOOZE + 1);
    logic [SCW-1:0] snooze_cnt_q;

    assign snooze_rej = snooze_req && (int'(snooze_cnt_q) >= MAX_SNOOZE);

    // Snoozes taken in the current ring event; held at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            snooze_cnt_q <= '0;
        else if (state_q == IDLE)
            snooze_cnt_q <= '0;
        else if (snooze_take)
            snooze_cnt_q <= snooze_cnt_q + 1'b1;
    end
`else
    logic unused_max_snooze;
    assign unused_max_snooze = (MAX_SNOOZE != 0);
    assign snooze_rej        = 1'b0;
`endif

    assign snooze_take = snooze_req && !snooze_rej;

    // Alarm FSM with registered flags; disabling the ringing slot or stop always returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            ring_idx_q <= '0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
            aud_en_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= load_err_s | wr_err | snooze_rej;
            unique case (state_q)
                IDLE: begin
                    if (min_start_s && match_hit) begin
                        state_q    <= RING;
                        ring_idx_q <= match_idx;
                        timer_q    <= TW'(RING_SEC);
                        ringing_q  <= 1'b1;
                        aud_en_q   <= 1'b1;
                    end
                end
                RING: begin
                    if (!ring_en || stop) begin
                        state_q   <= IDLE;
                        ringing_q <= 1'b0;
                        aud_en_q  <= 1'b0;
                    end else if (snooze_take) begin
                        state_q    <= SNOOZE;
                        timer_q    <= TW'(SNOOZE_SEC);
                        ringing_q  <= 1'b0;
                        snoozing_q <= 1'b1;
                        aud_en_q   <= 1'b0;
                    end else if (tick_s) begin
                        if (timer_q <= TW'(1)) begin
                            state_q   <= IDLE;
                            ringing_q <= 1'b0;
                            aud_en_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                end
                SNOOZE: begin
                    if (!ring_en || stop) begin
                        state_q    <= IDLE;
                        snoozing_q <= 1'b0;
                    end else if (tick_s) begin
                        if (timer_q <= TW'(1)) begin
                            state_q    <= RING;
                            timer_q    <= TW'(RING_SEC);
                            ringing_q  <= 1'b1;
                            snoozing_q <= 1'b0;
                            aud_en_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ringing_q  <= 1'b0;
                    snoozing_q <= 1'b0;
                    aud_en_q   <= 1'b0;
                end
            endcase
        end
    end

    assign time_hhmm = hhmm_s;
    assign sec_tick  = tick_s;
    assign ringing   = ringing_q;
    assign snoozing  = snoozing_q;
    assign ring_idx  = ring_idx_q;
    assign aud_en    = aud_en_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Directed bench for alarm_clock_multi: TICK_DIV=4, five slots, SNOOZE_SEC=5, RING_SEC=3, MAX_SNOOZE=2.
module tb_alarm_clock_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        time_load = 1'b0;
    logic [15:0] time_init = 16'h0000;
    logic        alarm_wr = 1'b0;
    logic [2:0]  alarm_idx = 3'd0;
    logic [15:0] alarm_hhmm = 16'h0000;
    logic [4:0]  alarm_en = 5'b00000;
    logic        snooze = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] time_hhmm;
    logic [7:0]  time_ss;
    logic        sec_tick, ringing, snoozing, aud_en, cfg_err;
    logic [2:0]  ring_idx;

    int vectors = 0;
    int miscompares = 0;

    alarm_clock_multi #(
        .TICK_DIV  (4),
        .N_ALARMS  (5),
        .SNOOZE_SEC(5),
        .RING_SEC  (3),
        .MAX_SNOOZE(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .time_load (time_load),
        .time_init (time_init),
        .alarm_wr  (alarm_wr),
        .alarm_idx (alarm_idx),
        .alarm_hhmm(alarm_hhmm),
        .alarm_en  (alarm_en),
        .snooze    (snooze),
        .stop      (stop),
        .time_hhmm (time_hhmm),
        .time_ss   (time_ss),
        .sec_tick  (sec_tick),
        .ringing   (ringing),
        .snoozing  (snoozing),
        .ring_idx  (ring_idx),
        .aud_en    (aud_en),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance to the next negedge where sec_tick is high, bounded to 8 cycles.
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = sec_tick;
        end
        if (!seen) begin
            miscompares++;
            $error("FAIL tick_timeout: observed no sec_tick expected one within 8 cycles");
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            wait_tick();
    endtask

    task automatic load_time(input logic [15:0] t);
        time_load = 1'b1;
        time_init = t;
        step();
        time_load = 1'b0;
    endtask

    task automatic write_slot(input logic [2:0] idx, input logic [15:0] t);
        alarm_wr   = 1'b1;
        alarm_idx  = idx;
        alarm_hhmm = t;
        step();
        alarm_wr = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Load 07:29:00, run one minute, and land on the first cycle the ring flags are visible.
    task automatic run_to_ring();
        load_time(16'h0729);
        ticks(60);
        step();
        step();
    endtask

    initial begin
        int cnt;

        // Reset state
        step();
        check("rst_hhmm", 32'(time_hhmm), 32'h0000);
        check("rst_ss", 32'(time_ss), 32'h00);
        check("rst_tick", 32'(sec_tick), 32'd0);
        check("rst_ring", 32'(ringing), 32'd0);
        check("rst_aud", 32'(aud_en), 32'd0);
        check("rst_cfg", 32'(cfg_err), 32'd0);
        rst = 1'b0;
        step();

        // Timekeeping: 23:59 roll-over and tick period
        load_time(16'h2359);
        check("load_hhmm", 32'(time_hhmm), 32'h2359);
        check("load_ss", 32'(time_ss), 32'h00);
        ticks(1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!sec_tick && cnt < 10);
        check("tick_period", 32'(cnt), 32'd4);
        step();
        check("ss_after_2", 32'(time_ss), 32'h02);
        ticks(57);
        step();
        check("ss_59", 32'(time_ss), 32'h59);
        check("hhmm_2359", 32'(time_hhmm), 32'h2359);
        wait_tick();
        step();
        check("wrap_hhmm", 32'(time_hhmm), 32'h0000);
        check("wrap_ss", 32'(time_ss), 32'h00);
        check("wrap_no_ring", 32'(ringing), 32'd0);

        // Slot programming and rejected writes
        write_slot(3'd2, 16'h0730);
        check("wr2_cfg", 32'(cfg_err), 32'd0);
        write_slot(3'd1, 16'h0730);
        check("wr1_cfg", 32'(cfg_err), 32'd0);
        write_slot(3'd1, 16'h0760);
        check("wr_badmin_cfg", 32'(cfg_err), 32'd1);
        write_slot(3'd5, 16'h0729);
        check("wr_badidx_cfg", 32'(cfg_err), 32'd1);
        step();
        check("cfg_pulse_end", 32'(cfg_err), 32'd0);

        // Two slots match 07:30: lowest enabled index rings
        alarm_en = 5'b00110;
        load_time(16'h0729);
        ticks(60);
        step();
        check("match_hhmm", 32'(time_hhmm), 32'h0730);
        check("match_ss", 32'(time_ss), 32'h00);
        check("pre_ring", 32'(ringing), 32'd0);
        step();
        check("ring", 32'(ringing), 32'd1);
        check("ring_idx", 32'(ring_idx), 32'd1);
        check("ring_aud", 32'(aud_en), 32'd1);

        // Snooze for 5 ticks, then ring again with the same slot
        pulse_snooze();
        check("snz", 32'(snoozing), 32'd1);
        check("snz_ring", 32'(ringing), 32'd0);
        check("snz_aud", 32'(aud_en), 32'd0);
        ticks(4);
        step();
        check("snz_4ticks", 32'(snoozing), 32'd1);
        wait_tick();
        step();
        check("resume_ring", 32'(ringing), 32'd1);
        check("resume_snz", 32'(snoozing), 32'd0);
        check("resume_idx", 32'(ring_idx), 32'd1);
        check("resume_aud", 32'(aud_en), 32'd1);
        pulse_stop();
        check("stop_ring", 32'(ringing), 32'd0);
        check("stop_snz", 32'(snoozing), 32'd0);
        check("stop_aud", 32'(aud_en), 32'd0);

        // Ring timeout after exactly RING_SEC ticks
        run_to_ring();
        check("to_ring", 32'(ringing), 32'd1);
        ticks(2);
        step();
        check("to_2ticks", 32'(ringing), 32'd1);
        wait_tick();
        step();
        check("to_3ticks", 32'(ringing), 32'd0);
        check("to_aud", 32'(aud_en), 32'd0);

        // time_load while ringing, then stop+snooze together
        run_to_ring();
        load_time(16'h0800);
        check("ld_ring_hhmm", 32'(time_hhmm), 32'h0800);
        check("ld_ring_keep", 32'(ringing), 32'd1);
        stop   = 1'b1;
        snooze = 1'b1;
        step();
        stop   = 1'b0;
        snooze = 1'b0;
        check("both_ring", 32'(ringing), 32'd0);
        check("both_snz", 32'(snoozing), 32'd0);

        // Disabling the ringing slot ends the ring
        alarm_en = 5'b00100;
        run_to_ring();
        check("en2_ring", 32'(ringing), 32'd1);
        check("en2_idx", 32'(ring_idx), 32'd2);
        alarm_en = 5'b00000;
        step();
        check("en_clr_ring", 32'(ringing), 32'd0);
        check("en_clr_aud", 32'(aud_en), 32'd0);

        // Rejected time load leaves time unchanged
        load_time(16'h1200);
        time_load = 1'b1;
        time_init = 16'h2460;
        step();
        time_load = 1'b0;
        check("badload_cfg", 32'(cfg_err), 32'd1);
        check("badload_hhmm", 32'(time_hhmm), 32'h1200);
        check("badload_ss", 32'(time_ss), 32'h00);
        step();
        check("badload_pulse", 32'(cfg_err), 32'd0);

        // Repeated snoozes, then asynchronous reset mid-ring
        alarm_en = 5'b00010;
        run_to_ring();
        check("lim_idx", 32'(ring_idx), 32'd1);
        for (int k = 0; k < 2; k++) begin
            pulse_snooze();
            check("lim_snz", 32'(snoozing), 32'd1);
            ticks(5);
            step();
            check("lim_back", 32'(ringing), 32'd1);
        end
        pulse_snooze();
`ifdef ALARM_SNOOZE_LIMIT_EN
        check("lim3_ring", 32'(ringing), 32'd1);
        check("lim3_snz", 32'(snoozing), 32'd0);
        check("lim3_cfg", 32'(cfg_err), 32'd1);
`else
        check("nolim3_snz", 32'(snoozing), 32'd1);
        check("nolim3_cfg", 32'(cfg_err), 32'd0);
        ticks(5);
        step();
        check("nolim3_back", 32'(ringing), 32'd1);
`endif
        check("pre_rst_aud", 32'(aud_en), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_aud", 32'(aud_en), 32'd0);
        check("arst_ring", 32'(ringing), 32'd0);
        check("arst_snz", 32'(snoozing), 32'd0);
        check("arst_idx", 32'(ring_idx), 32'd0);
        check("arst_hhmm", 32'(time_hhmm), 32'h0000);
        check("arst_ss", 32'(time_ss), 32'h00);
        check("arst_cfg", 32'(cfg_err), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_ring", 32'(ringing), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
